// File: rtl/obc_da_serial_mac_if.sv
// rtl/obc_da_serial_mac_if.sv - sample-set input and result output handshake bundle for the OBC serial MAC
interface obc_da_serial_mac_if #(
    parameter int DATA_W = 16,
    parameter int ROM_W  = 32
);
    localparam int ACC_W = ROM_W + 2 + DATA_W;

    logic                  in_valid;
    logic                  in_ready;
    logic [8*DATA_W-1:0]   in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [ACC_W-1:0]      out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/obc_da_serial_mac.sv
// rtl/obc_da_serial_mac.sv - bit-serial OBC shift-accumulate engine; OBC_DONE_CNT_EN adds done_cnt
module obc_da_serial_mac #(
    parameter int  DATA_W = 16,
    parameter int  ROM_W  = 32,
    localparam int ACC_W  = ROM_W + 2 + DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    obc_da_serial_mac_if.slave bus,
    output logic               x0,
    output logic               x1,
    output logic               x2,
    output logic               x3,
    output logic               x4,
    output logic               x5,
    output logic               x6,
    output logic               x7,
    input  logic [ROM_W-1:0]   rom_out0,
    input  logic [ROM_W-1:0]   rom_out1,
    input  logic [ROM_W-1:0]   rom_out2,
    input  logic [ROM_W-1:0]   rom_out3,
    input  logic [ROM_W-1:0]   rom_offset
`ifdef OBC_DONE_CNT_EN
    ,
    output logic [15:0]        done_cnt
`endif
);
    localparam int RSUM_W = ROM_W + 2;
    localparam int CNT_W  = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_OFFSET,
        S_HOLD
    } state_t;

    state_t state_q, state_d;

    // The sample MSB lives in x_q, so the shift registers only keep the remaining DATA_W-1 bits.
    logic [7:0][DATA_W-2:0]    sh_q, sh_d;
    logic [7:0]                x_q, x_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [ACC_W-1:0]   out_data_q, out_data_d;
    logic                      out_valid_q, out_valid_d;

    logic signed [RSUM_W-1:0]  rsum;
    logic signed [ACC_W-1:0]   rsum_ext;
    logic signed [ACC_W-1:0]   acc_off;

    // Exact sum of the four ROM words; two guard bits absorb any carry.
    always_comb begin
        rsum = RSUM_W'($signed(rom_out0)) + RSUM_W'($signed(rom_out1))
             + RSUM_W'($signed(rom_out2)) + RSUM_W'($signed(rom_out3));
    end

    assign rsum_ext = ACC_W'(rsum);
    assign acc_off  = acc_q + ACC_W'($signed(rom_offset));

    // Next-state and datapath updates for the IDLE/SHIFT/OFFSET/HOLD sequence.
    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        x_d         = '0;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    for (int k = 0; k < 8; k++) begin
                        sh_d[k] = bus.in_data[k*DATA_W +: DATA_W-1];
                        x_d[k]  = bus.in_data[k*DATA_W + DATA_W - 1];
                    end
                    acc_d   = '0;
                    cnt_d   = CNT_TOP;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // The first slice is the sign bit, so its weight is negative.
                if (cnt_q == CNT_TOP) begin
                    acc_d = -rsum_ext;
                end else begin
                    acc_d = (acc_q <<< 1) + rsum_ext;
                end
                for (int k = 0; k < 8; k++) begin
                    x_d[k]  = (cnt_q != '0) ? sh_q[k][DATA_W-2] : 1'b0;
                    sh_d[k] = sh_q[k] << 1;
                end
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == '0) begin
                    state_d = S_OFFSET;
                end
            end
            S_OFFSET: begin
                acc_d       = acc_off;
                out_data_d  = acc_off;
                out_valid_d = 1'b1;
                state_d     = S_HOLD;
            end
            S_HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sh_q        <= '0;
            x_q         <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            x_q         <= x_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

    assign x0 = x_q[0];
    assign x1 = x_q[1];
    assign x2 = x_q[2];
    assign x3 = x_q[3];
    assign x4 = x_q[4];
    assign x5 = x_q[5];
    assign x6 = x_q[6];
    assign x7 = x_q[7];

`ifdef OBC_DONE_CNT_EN
    logic [15:0] done_q;

    // Count consumed results; wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q <= '0;
        end else if (out_valid_q && bus.out_ready) begin
            done_q <= done_q + 16'd1;
        end
    end

    assign done_cnt = done_q;
`endif

endmodule

// File: tb/tb_obc_da_serial_mac.sv
// tb/tb_obc_da_serial_mac.sv - self-checking bench for obc_da_serial_mac (stub ROM and DFT-bank ROM instances)
module tb_obc_da_serial_mac;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    obc_da_serial_mac_if #(.DATA_W(4),  .ROM_W(32)) s_if ();
    obc_da_serial_mac_if #(.DATA_W(16), .ROM_W(32)) b_if ();

    wire [7:0]          sx;
    wire [7:0]          bx;
    logic [31:0]        s_off;
    logic [31:0]        b_off;
    logic signed [31:0] rom_b [4];
    int                 coef [4][8];
    int                 sin_t [16];
`ifdef OBC_DONE_CNT_EN
    wire [15:0]         s_done;
    wire [15:0]         b_done;
`endif

    obc_da_serial_mac #(.DATA_W(4), .ROM_W(32)) u_small (
        .clk        (clk),
        .rst        (rst),
        .bus        (s_if),
        .x0         (sx[0]),
        .x1         (sx[1]),
        .x2         (sx[2]),
        .x3         (sx[3]),
        .x4         (sx[4]),
        .x5         (sx[5]),
        .x6         (sx[6]),
        .x7         (sx[7]),
        .rom_out0   (32'd1),
        .rom_out1   (32'd0),
        .rom_out2   (32'd0),
        .rom_out3   (32'd0),
        .rom_offset (s_off)
`ifdef OBC_DONE_CNT_EN
        ,
        .done_cnt   (s_done)
`endif
    );

    obc_da_serial_mac #(.DATA_W(16), .ROM_W(32)) u_big (
        .clk        (clk),
        .rst        (rst),
        .bus        (b_if),
        .x0         (bx[0]),
        .x1         (bx[1]),
        .x2         (bx[2]),
        .x3         (bx[3]),
        .x4         (bx[4]),
        .x5         (bx[5]),
        .x6         (bx[6]),
        .x7         (bx[7]),
        .rom_out0   (rom_b[0]),
        .rom_out1   (rom_b[1]),
        .rom_out2   (rom_b[2]),
        .rom_out3   (rom_b[3]),
        .rom_offset (b_off)
`ifdef OBC_DONE_CNT_EN
        ,
        .done_cnt   (b_done)
`endif
    );

    // Imaginary-bank ROM: word m for address x is sum of coef[m][k] over set bits x_k.
    always_comb begin
        for (int m = 0; m < 4; m++) begin
            rom_b[m] = 0;
            for (int k = 0; k < 8; k++) begin
                if (bx[k]) rom_b[m] = rom_b[m] + coef[m][k];
            end
        end
    end

    typedef struct packed {
        logic [127:0] data;
        logic [31:0]  off;
        logic [63:0]  exp;
    } vec_t;

    vec_t        vec [6];
    int          total, bad, cyc;
    longint      sq [$];
    longint      bq [$];
    int          b_pops [$];
    longint      s_exp, b_exp;
    bit          s_acc, b_acc;
    logic [15:0] tr [8];

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s act=%0d req=%0d", name, act, req);
        end
    endtask

    function automatic longint model(input logic [127:0] d, input logic [31:0] off);
        longint             r;
        logic signed [15:0] smp;
        r = longint'($signed(off));
        for (int k = 0; k < 8; k++) begin
            smp = d[k*16 +: 16];
            for (int m = 0; m < 4; m++) r += longint'(coef[m][k]) * longint'(smp);
        end
        return r;
    endfunction

    // Scoreboard step: record handshakes that the coming edge will take, then advance one cycle.
    task automatic tick();
        s_acc = 1'b0;
        b_acc = 1'b0;
        if (s_if.in_valid && s_if.in_ready) begin
            sq.push_back(s_exp);
            s_acc = 1'b1;
        end
        if (s_if.out_valid && s_if.out_ready) begin
            if (sq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL s_unexpected act=%0d req=none", longint'($signed(s_if.out_data)));
            end else begin
                chk("s_result", longint'($signed(s_if.out_data)), sq.pop_front());
            end
        end
        if (b_if.in_valid && b_if.in_ready) begin
            bq.push_back(b_exp);
            b_acc = 1'b1;
        end
        if (b_if.out_valid && b_if.out_ready) begin
            b_pops.push_back(cyc);
            if (bq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL b_unexpected act=%0d req=none", longint'($signed(b_if.out_data)));
            end else begin
                chk("b_result", longint'($signed(b_if.out_data)), bq.pop_front());
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_small(input logic [31:0] off, input longint req, output int lat);
        s_off           = off;
        s_exp           = req;
        s_if.in_data    = $urandom;
        s_if.in_valid   = 1'b1;
        s_if.out_ready  = 1'b1;
        tick();
        s_if.in_valid   = 1'b0;
        lat = 0;
        while (!s_if.out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic load_big(input int i);
        b_if.in_data = vec[i].data;
        b_off        = vec[i].off;
        b_exp        = $signed(vec[i].exp);
    endtask

    initial begin
        int          n;
        int          idx;
        int          guard;
        int          npop;
        logic [15:0] d16;

        total = 0;
        bad   = 0;
        cyc   = 0;
        sin_t = '{0, 6270, 11585, 15137, 16384, 15137, 11585, 6270,
                  0, -6270, -11585, -15137, -16384, -15137, -11585, -6270};
        for (int m = 0; m < 4; m++)
            for (int k = 0; k < 8; k++)
                coef[m][k] = -sin_t[((2*m + 1) * k) % 16];

        vec[0].data = {112'd0, 16'h7FFF};
        vec[0].off  = 32'd0;
        vec[1].data = {8{16'h8000}};
        vec[1].off  = -32'sd7;
        vec[2].data = {8{16'h7FFF}};
        vec[2].off  = 32'd100;
        for (int i = 3; i < 6; i++) begin
            vec[i].data = {$urandom, $urandom, $urandom, $urandom};
            vec[i].off  = 32'($urandom_range(2000)) - 32'd1000;
        end
        for (int i = 0; i < 6; i++) vec[i].exp = model(vec[i].data, vec[i].off);

        rst            = 1'b1;
        s_if.in_valid  = 1'b0;
        s_if.out_ready = 1'b0;
        s_if.in_data   = '0;
        b_if.in_valid  = 1'b0;
        b_if.out_ready = 1'b0;
        b_if.in_data   = '0;
        s_off = '0;
        b_off = '0;
        s_exp = 0;
        b_exp = 0;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;

        chk("rst_s_in_ready",  s_if.in_ready, 1);
        chk("rst_s_out_valid", s_if.out_valid, 0);
        chk("rst_s_out_data",  longint'(s_if.out_data), 0);
        chk("rst_s_x",         sx, 0);
        chk("rst_b_in_ready",  b_if.in_ready, 1);
        chk("rst_b_out_valid", b_if.out_valid, 0);
        chk("rst_b_x",         bx, 0);

        run_small(32'd0, -1, n);
        chk("s_latency", n, 5);
        chk("s_x_hold", sx, 0);
        tick();
`ifdef OBC_DONE_CNT_EN
        chk("s_done_1", s_done, 1);
`endif
        run_small(32'd5, 4, n);
        chk("s_latency_off5", n, 5);
        tick();
`ifdef OBC_DONE_CNT_EN
        chk("s_done_2", s_done, 2);
`endif

        run_small(-32'sd3, -4, n);
        chk("s_latency_hold", n, 5);
        s_if.out_ready = 1'b0;
        s_if.in_valid  = 1'b1;
        s_if.in_data   = $urandom;
        s_exp          = 999;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("s_hold_data",  longint'($signed(s_if.out_data)), -4);
            chk("s_hold_valid", s_if.out_valid, 1);
            chk("s_hold_ready", s_if.in_ready, 0);
        end
        s_if.in_valid  = 1'b0;
        s_if.out_ready = 1'b1;
        tick();
        chk("s_release_ready", s_if.in_ready, 1);
        chk("s_release_valid", s_if.out_valid, 0);
        chk("s_sb_empty", sq.size(), 0);

        s_off         = '0;
        s_exp         = -1;
        s_if.in_data  = $urandom;
        s_if.in_valid = 1'b1;
        tick();
        s_if.in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_in_ready",  s_if.in_ready, 1);
        chk("midrst_out_valid", s_if.out_valid, 0);
        chk("midrst_x",         sx, 0);
        chk("midrst_out_data",  longint'(s_if.out_data), 0);
        sq.delete();
        run_small(32'd2, 1, n);
        chk("s_latency_fresh", n, 5);
        tick();
`ifdef OBC_DONE_CNT_EN
        chk("s_done_after_rst", s_done, 1);
`endif

        b_if.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            load_big(i);
            b_if.in_valid = 1'b1;
            tick();
            b_if.in_valid = 1'b0;
            chk("b_accept", b_acc, 1);
            for (int j = 0; j < 16; j++) begin
                for (int k = 0; k < 8; k++) tr[k] = {tr[k][14:0], bx[k]};
                tick();
            end
            for (int k = 0; k < 8; k++) begin
                d16 = vec[i].data[k*16 +: 16];
                chk("b_xtrace", tr[k], d16);
            end
            n = 0;
            while (!b_if.out_valid && n < 40) begin
                tick();
                n++;
            end
            chk("b_latency", n, 1);
            chk("b_x_hold", bx, 0);
            tick();
        end

        b_pops.delete();
        idx   = 0;
        guard = 0;
        load_big(0);
        b_if.in_valid = 1'b1;
        while (b_pops.size() < 3 && guard < 200) begin
            npop = b_pops.size();
            tick();
            guard++;
            if (b_pops.size() != npop) begin
                idx++;
                if (idx < 3) load_big(idx);
                else b_if.in_valid = 1'b0;
            end
        end
        b_if.in_valid = 1'b0;
        chk("b2b_count", b_pops.size(), 3);
        if (b_pops.size() == 3) begin
            chk("b2b_interval1", b_pops[1] - b_pops[0], 19);
            chk("b2b_interval2", b_pops[2] - b_pops[1], 19);
        end
        chk("b_sb_empty", bq.size(), 0);
`ifdef OBC_DONE_CNT_EN
        chk("b_done", b_done, 9);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
